dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports m0_req / m1_req  input  1  requester n wants one memory access this cycle.
REQ-006 SHALL have ports m0_we / m1_we  input  1  access type: 1 write, 0 read.
REQ-007 SHALL have ports m0_addr / m1_addr  input  ADDR_WIDTH  access address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have ports m0_gnt / m1_gnt  output  1  combinational grant; access accepted this cycle.
REQ-010 SHALL have ports m0_rvalid / m1_rvalid  output  1  registered read data valid, one cycle.
REQ-011 SHALL have ports m0_rdata / m1_rdata  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have ports mem_addr  output  ADDR_WIDTH, mem_data_in  output  DATA_WIDTH, mem_we  output  1, mem_re  output  1, driving the single-port data memory.
REQ-013 SHALL have port mem_data_out  input  DATA_WIDTH  combinational read data from the memory.

Function
REQ-014 SHALL grant at most one requester per cycle; m0_gnt and m1_gnt never both 1.
REQ-015 SHALL grant a sole requester in the same cycle its req is high (zero-cycle arbitration).
REQ-016 SHALL, when both request, grant the requester not granted most recently (round-robin pointer last_gnt, 1 bit).
REQ-017 SHALL update last_gnt only on cycles with a grant; idle cycles leave it unchanged.
REQ-018 SHALL drive mem_addr, mem_data_in, mem_we from the granted requester; mem_we = granted we; mem_re = grant and not we.
REQ-019 SHALL drive mem_we=0, mem_re=0, mem_addr=0, mem_data_in=0 when no grant.
REQ-020 SHALL, on a granted read, capture mem_data_out at the edge into that requester's rdata register and assert its rvalid for exactly the next cycle (read latency 1).
REQ-021 SHALL hold mn_rdata at its last captured value when mn_rvalid is 0.
REQ-022 SHALL not assert rvalid for writes; a write completes at the granting edge.
REQ-023 Requester contract: a non-granted requester keeps req, we, addr, wdata stable until granted; the arbiter does not buffer requests.
REQ-024 SHALL allow back-to-back grants to the same requester when the other does not request; a read following a write to the same address returns the written data.
REQ-025 SHALL count consecutive cycles a requester waits with req high and no gnt (per-requester 4-bit saturating counter), cleared on grant or req low.

Reset
REQ-026 SHALL, while rst is high at an edge, clear m0_rvalid, m1_rvalid, m0_rdata, m1_rdata to 0, set last_gnt=1 (m0 wins first tie), clear wait counters.
REQ-027 SHALL suppress grants and hold mem_we=0, mem_re=0 during any cycle rst is high; a read granted in the cycle before rst rises yields no rvalid.

Configuration
REQ-028 Macro DMEM_ARB_RR_EN SHALL select the tie policy.
REQ-029 With DMEM_ARB_RR_EN defined: round-robin per REQ-016.
REQ-030 Without DMEM_ARB_RR_EN: fixed priority m0 over m1, except m1 is granted when its wait counter reaches 8; last_gnt unused.

Verification
REQ-031 m0 alone writes addr 3 data 0xDEADBEEF, then reads addr 3 -> m0_gnt both cycles, mem_we=1 first cycle, m0_rvalid=1 with m0_rdata=0xDEADBEEF one cycle after read grant.
REQ-032 Both request reads continuously, addrs 1 and 2, RR build -> grants alternate m0,m1,m0,m1 starting with m0 after reset; each rvalid one cycle after its grant.
REQ-033 Both request continuously, non-RR build -> m0 granted 8 cycles, m1 granted on 9th, counter cleared, pattern repeats.
REQ-034 m1 read granted at cycle N, rst high at cycle N+1 -> m1_rvalid=0 at N+1, m1_rdata=0, no grants during reset.
REQ-035 Idle bus (no req) -> mem_we=0, mem_re=0, mem_addr=0, no rvalid, last_gnt unchanged.
REQ-036 Every cycle of all tests -> m0_gnt and m1_gnt never simultaneously 1; a rvalid only follows a granted read.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter in front of a single-port data memory. Arbitration is
// combinational: a requester is granted in the same cycle its req is high.
// Writes complete at the granting edge. Reads capture the combinational memory
// output at the granting edge and return it with a one-cycle rvalid pulse on
// the owning requester's port.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> ties alternate round-robin (last_gnt pointer,
//                                m0 wins the first tie after reset)
//                   undefined -> m0 has fixed priority; m1 is forced through
//                                once it has waited 8 consecutive cycles
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m0_req/m1_req                 access request (held until granted)
//   m0_we/m1_we                   1 = write, 0 = read
//   m0_addr/m1_addr               access address
//   m0_wdata/m1_wdata             write data
//   m0_gnt/m1_gnt                 combinational grant, at most one high
//   m0_rvalid/m1_rvalid           one-cycle read-data-valid pulse
//   m0_rdata/m1_rdata             read data, held between reads
//   mem_addr/mem_data_in          address / write data to the memory
//   mem_we/mem_re                 memory write / read strobes
//   mem_data_out                  combinational read data from the memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam logic [3:0] WAIT_MAX   = 4'hF;
    localparam logic [3:0] WAIT_LIMIT = 4'd8;

    logic                  gnt0;
    logic                  gnt1;
    logic                  starve0;
    logic                  starve1;
    logic [3:0]            wait0;
    logic [3:0]            wait1;
    logic                  rd_vld0_p1;
    logic                  rd_vld1_p1;
    logic [DATA_WIDTH-1:0] rd_data0_p1;
    logic [DATA_WIDTH-1:0] rd_data1_p1;
`ifdef DMEM_ARB_RR_EN
    logic                  last_gnt;   // 0 = m0 granted most recently, 1 = m1
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == WAIT_MAX) ? v : v + 4'd1;
    endfunction

    assign starve0 = (wait0 >= WAIT_LIMIT);
    assign starve1 = (wait1 >= WAIT_LIMIT);

    // Grant decision. A starved requester always takes a tie; under the
    // hold-until-granted contract only m1 in the fixed-priority build can
    // ever get there, but the check keeps the tie rule total in both builds.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req && !m1_req) begin
                gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                if (starve0 != starve1) begin
                    gnt0 = starve0;
                    gnt1 = starve1;
                end else begin
`ifdef DMEM_ARB_RR_EN
                    gnt0 = last_gnt;
                    gnt1 = ~last_gnt;
`else
                    gnt0 = 1'b1;
`endif
                end
            end
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Memory-side mux: everything is zero on cycles without a grant.
    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        if (gnt0) begin
            mem_addr    = m0_addr;
            mem_data_in = m0_wdata;
            mem_we      = m0_we;
            mem_re      = ~m0_we;
        end else if (gnt1) begin
            mem_addr    = m1_addr;
            mem_data_in = m1_wdata;
            mem_we      = m1_we;
            mem_re      = ~m1_we;
        end
    end

    // Arbitration state: round-robin pointer and per-requester wait counters.
`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wait0 <= 4'd0;
            wait1 <= 4'd0;
        end else begin
            wait0 <= (m0_req && !gnt0) ? sat_inc(wait0) : 4'd0;
            wait1 <= (m1_req && !gnt1) ? sat_inc(wait1) : 4'd0;
        end
    end

    // ---- stage p0 -> p1: read data capture at the granting edge ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld0_p1  <= 1'b0;
            rd_vld1_p1  <= 1'b0;
            rd_data0_p1 <= '0;
            rd_data1_p1 <= '0;
        end else begin
            rd_vld0_p1 <= gnt0 & ~m0_we;
            rd_vld1_p1 <= gnt1 & ~m1_we;
            if (gnt0 && !m0_we) begin
                rd_data0_p1 <= mem_data_out;
            end
            if (gnt1 && !m1_we) begin
                rd_data1_p1 <= mem_data_out;
            end
        end
    end

    // A reset arriving right after a read grant must cancel that read's
    // response in the same cycle, before the registers themselves clear.
    assign m0_rvalid = rd_vld0_p1 & ~rst;
    assign m1_rvalid = rd_vld1_p1 & ~rst;
    assign m0_rdata  = rst ? '0 : rd_data0_p1;
    assign m1_rdata  = rst ? '0 : rd_data1_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a behavioural 16-word memory behind it.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling
// edge. A background process checks grant exclusivity and rvalid causality
// every cycle.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic          mem_we, mem_re;

    logic [DW-1:0] mem [16];

    int checks = 0;
    int errors = 0;

    logic pend0 = 1'b0;
    logic pend1 = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_we(mem_we), .mem_re(mem_re), .mem_data_out(mem_data_out)
    );

    assign mem_data_out = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data_in;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants: one grant at most, and rvalid only one cycle
    // after a granted read (and never while reset is high).
    always @(negedge clk) begin
        chk("excl_gnt", {63'd0, m0_gnt & m1_gnt}, 64'd0);
        chk("rv0_cause", {63'd0, m0_rvalid}, {63'd0, pend0 & ~rst});
        chk("rv1_cause", {63'd0, m1_rvalid}, {63'd0, pend1 & ~rst});
        pend0 = m0_gnt & ~m0_we;
        pend1 = m1_gnt & ~m1_we;
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd1; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 4'd0; m1_wdata = '0;

        // Reset cycle: request present but no grant, no strobes.
        @(negedge clk);
        chk("rst_gnt0", {63'd0, m0_gnt}, 64'd0);
        chk("rst_mem_re", {63'd0, mem_re}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        tick();
        rst = 1'b0; m0_req = 1'b0;

        // Post-reset idle.
        @(negedge clk);
        chk("post_rst_rv0", {63'd0, m0_rvalid}, 64'd0);
        chk("post_rst_rd0", {32'd0, m0_rdata}, 64'd0);
        chk("post_rst_rd1", {32'd0, m1_rdata}, 64'd0);
        chk("idle_addr", {60'd0, mem_addr}, 64'd0);
        chk("idle_re", {63'd0, mem_re}, 64'd0);
        chk("idle_we", {63'd0, mem_we}, 64'd0);

        // m0 writes 0xDEADBEEF to addr 3.
        tick();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 4'd3; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_gnt0", {63'd0, m0_gnt}, 64'd1);
        chk("wr_gnt1", {63'd0, m1_gnt}, 64'd0);
        chk("wr_mem_we", {63'd0, mem_we}, 64'd1);
        chk("wr_mem_re", {63'd0, mem_re}, 64'd0);
        chk("wr_addr", {60'd0, mem_addr}, 64'd3);
        chk("wr_data", {32'd0, mem_data_in}, 64'hDEADBEEF);

        // m0 reads addr 3 back-to-back.
        tick();
        m0_we = 1'b0; m0_wdata = '0;
        @(negedge clk);
        chk("rd_gnt0", {63'd0, m0_gnt}, 64'd1);
        chk("rd_mem_re", {63'd0, mem_re}, 64'd1);
        chk("rd_mem_we", {63'd0, mem_we}, 64'd0);
        chk("wr_no_rv", {63'd0, m0_rvalid}, 64'd0);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("rd_rv0", {63'd0, m0_rvalid}, 64'd1);
        chk("rd_data0", {32'd0, m0_rdata}, 64'hDEADBEEF);
        chk("rd_rv1", {63'd0, m1_rvalid}, 64'd0);
        tick();
        @(negedge clk);
        chk("rv0_pulse", {63'd0, m0_rvalid}, 64'd0);
        chk("rd0_hold", {32'd0, m0_rdata}, 64'hDEADBEEF);

        // m1 writes addr 5, then m0 reads it.
        tick();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 4'd5; m1_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("m1wr_gnt1", {63'd0, m1_gnt}, 64'd1);
        chk("m1wr_addr", {60'd0, mem_addr}, 64'd5);
        tick();
        m1_req = 1'b0; m1_we = 1'b0; m1_wdata = '0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd5;
        @(negedge clk);
        chk("x_gnt0", {63'd0, m0_gnt}, 64'd1);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("x_rd0", {32'd0, m0_rdata}, 64'hCAFEF00D);

        // Idle cycles leave the tie pointer alone (m0 was granted last).
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("idle_re_k", {63'd0, mem_re}, 64'd0);
            chk("idle_addr_k", {60'd0, mem_addr}, 64'd0);
        end
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'd2;
        @(negedge clk);
`ifdef DMEM_ARB_RR_EN
        chk("tie_after_idle_g1", {63'd0, m1_gnt}, 64'd1);
`else
        chk("tie_after_idle_g0", {63'd0, m0_gnt}, 64'd1);
`endif

        // Reset, then both read continuously.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef DMEM_ARB_RR_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_gnt0", {63'd0, m0_gnt}, {63'd0, (k % 2) == 0});
            chk("rr_gnt1", {63'd0, m1_gnt}, {63'd0, (k % 2) == 1});
            if (k > 0) begin
                chk("rr_rv0", {63'd0, m0_rvalid}, {63'd0, (k % 2) == 1});
                chk("rr_rv1", {63'd0, m1_rvalid}, {63'd0, (k % 2) == 0});
            end
            if (k > 1) begin
                chk("rr_rd0", {32'd0, m0_rdata}, 64'h1000_0001);
                chk("rr_rd1", {32'd0, m1_rdata}, 64'h1000_0002);
            end
            tick();
        end
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("fp_gnt0", {63'd0, m0_gnt}, {63'd0, (k % 9) != 8});
            chk("fp_gnt1", {63'd0, m1_gnt}, {63'd0, (k % 9) == 8});
            if (k == 9 || k == 18) begin
                chk("fp_rv1", {63'd0, m1_rvalid}, 64'd1);
                chk("fp_rd1", {32'd0, m1_rdata}, 64'h1000_0002);
            end
            if (k > 0) chk("fp_rd0", {32'd0, m0_rdata}, 64'h1000_0001);
            tick();
        end
`endif
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();

        // m1 read granted at cycle N, reset at N+1 cancels its response.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'd2;
        @(negedge clk);
        chk("n_gnt1", {63'd0, m1_gnt}, 64'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("n1_rv1", {63'd0, m1_rvalid}, 64'd0);
        chk("n1_rd1", {32'd0, m1_rdata}, 64'd0);
        chk("n1_gnt1", {63'd0, m1_gnt}, 64'd0);
        chk("n1_re", {63'd0, mem_re}, 64'd0);
        tick();
        rst = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        chk("n2_rv1", {63'd0, m1_rvalid}, 64'd0);
        chk("n2_rd1", {32'd0, m1_rdata}, 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
